// File: rtl/alu_dec_pkg.sv
// ALU decode / condition package: op codes, cmd and cond encodings,
// NZCV bit positions and the data-processing decode function.
package alu_dec_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [2:0] alu_ctl;
    logic [1:0] flag_w;
    logic       cmp_cls;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(
    input logic       alu_op,
    input logic [3:0] cmd,
    input logic       s
  );
    dec_t d;
    d = '{alu_ctl: ALU_ADD, flag_w: 2'b00,
          cmp_cls: 1'b0, illegal: 1'b0};
    if (alu_op) begin
      case (cmd)
        CMD_ADD: d.alu_ctl = ALU_ADD;
        CMD_SUB: d.alu_ctl = ALU_SUB;
        CMD_AND: d.alu_ctl = ALU_AND;
        CMD_ORR: d.alu_ctl = ALU_ORR;
        CMD_EOR: d.alu_ctl = ALU_EOR;
        CMD_MOV: d.alu_ctl = ALU_MOV;
        CMD_CMP: d.alu_ctl = ALU_SUB;
        CMD_CMN: d.alu_ctl = ALU_ADD;
        default: d.illegal = 1'b1;
      endcase
      d.cmp_cls = (cmd == CMD_CMP) || (cmd == CMD_CMN);
      if (d.cmp_cls)
        d.flag_w = 2'b11;
      else if (s && !d.illegal)
        d.flag_w = (cmd == CMD_ADD || cmd == CMD_SUB)
                   ? 2'b11 : 2'b10;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_decode_cond_unit_cond_check.sv
// Pure combinational condition evaluator: cond field against NZCV.
// Kept standalone so a branch predictor can reuse it.
module cond_check
  import alu_dec_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_decode_cond_unit.sv
// Registered ALU decode stage with NZCV flags and conditional write gating.
// Optional sticky illegal-op trap: define ALU_DEC_ILLEGAL_TRAP_EN.
module alu_decode_cond_unit
  import alu_dec_pkg::*;
#(
  parameter int         ALUCTRL_W = 3,
  parameter logic [3:0] FLAG_RST  = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 alu_op,
  input  logic [3:0]           funct_cmd,
  input  logic                 funct_s,
  input  logic [3:0]           cond,
  input  logic                 reg_w_in,
  input  logic                 mem_w_in,
  input  logic                 pc_s_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           flag_w,
  output logic                 cond_ex,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 pc_src,
  input  logic [3:0]           alu_flags,
  output logic [3:0]           flags,
  output logic                 illegal
);

  logic       valid_q, valid_d;
  logic [2:0] ctl_q, ctl_d;
  logic [1:0] fw_q, fw_d;
  logic [3:0] cond_q, cond_d;
  logic       rw_q, rw_d;
  logic       mw_q, mw_d;
  logic       ps_q, ps_d;
  logic [3:0] flags_q, flags_d;
  logic       accept, commit;
  dec_t       dec;

  assign accept = in_valid & in_ready;
  assign commit = valid_q & out_ready;
  assign dec    = decode(alu_op, funct_cmd, funct_s);

  cond_check u_cond (
    .cond    (cond_q),
    .nzcv    (flags_q),
    .cond_ex (cond_ex)
  );

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
  logic ill_op_q, ill_op_d;
  logic illegal_q, illegal_d;

  assign in_ready = ~illegal_q & (~valid_q | out_ready);
  assign illegal  = illegal_q;

  always_comb begin
    ill_op_d  = accept ? dec.illegal : ill_op_q;
    illegal_d = illegal_q | (commit & ill_op_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_op_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ill_op_q  <= ill_op_d;
      illegal_q <= illegal_d;
    end
  end
`else
  assign in_ready = ~valid_q | out_ready;
  assign illegal  = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    fw_d    = fw_q;
    cond_d  = cond_q;
    rw_d    = rw_q;
    mw_d    = mw_q;
    ps_d    = ps_q;
    flags_d = flags_q;
    if (accept) begin
      valid_d = 1'b1;
      ctl_d   = dec.alu_ctl;
      fw_d    = dec.flag_w;
      cond_d  = cond;
      rw_d    = reg_w_in & ~dec.cmp_cls & ~dec.illegal;
      mw_d    = mem_w_in & ~dec.illegal;
      ps_d    = pc_s_in & ~dec.illegal;
    end else if (commit) begin
      valid_d = 1'b0;
    end
    // Flags use the pre-commit value for cond_ex, then update.
    if (commit && cond_ex) begin
      if (fw_q[1]) flags_d[3:2] = alu_flags[3:2];
      if (fw_q[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  // Reset cond to NV so the gated writes read 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= ALU_ADD;
      fw_q    <= 2'b00;
      cond_q  <= COND_NV;
      rw_q    <= 1'b0;
      mw_q    <= 1'b0;
      ps_q    <= 1'b0;
      flags_q <= FLAG_RST;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      fw_q    <= fw_d;
      cond_q  <= cond_d;
      rw_q    <= rw_d;
      mw_q    <= mw_d;
      ps_q    <= ps_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    alu_control      = '0;
    alu_control[2:0] = ctl_q;
  end

  assign out_valid = valid_q;
  assign flag_w    = fw_q;
  assign reg_write = rw_q & cond_ex;
  assign mem_write = mw_q & cond_ex;
  assign pc_src    = ps_q & cond_ex;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_decode_cond_unit.sv
// Table-driven bench for alu_decode_cond_unit plus handshake,
// stall, illegal-op and reset corner sequences.
module tb_alu_decode_cond_unit;

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic       alu_op;
  logic [3:0] funct_cmd;
  logic       funct_s;
  logic [3:0] cond;
  logic       reg_w_in, mem_w_in, pc_s_in;
  logic       out_valid, out_ready;
  logic [2:0] alu_control;
  logic [1:0] flag_w;
  logic       cond_ex, reg_write, mem_write, pc_src;
  logic [3:0] alu_flags, flags;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_decode_cond_unit #(
    .ALUCTRL_W (3),
    .FLAG_RST  (4'b0100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct_cmd   (funct_cmd),
    .funct_s     (funct_s),
    .cond        (cond),
    .reg_w_in    (reg_w_in),
    .mem_w_in    (mem_w_in),
    .pc_s_in     (pc_s_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .flag_w      (flag_w),
    .cond_ex     (cond_ex),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .pc_src      (pc_src),
    .alu_flags   (alu_flags),
    .flags       (flags),
    .illegal     (illegal)
  );

  typedef struct {
    logic       op;
    logic [3:0] cmd;
    logic       s;
    logic [3:0] cnd;
    logic       rw, mw, ps;
    logic [3:0] af;
    logic [2:0] e_ctl;
    logic [1:0] e_fw;
    logic       e_cx, e_rw, e_mw, e_ps;
    logic [3:0] e_flags;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [3:0] cmd,
                       input logic s, input logic [3:0] cnd,
                       input logic rw, input logic mw,
                       input logic ps);
    alu_op    = op;
    funct_cmd = cmd;
    funct_s   = s;
    cond      = cnd;
    reg_w_in  = rw;
    mem_w_in  = mw;
    pc_s_in   = ps;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // op cmd s cond rw mw ps alu_flags | ctl fw cx rw mw ps flags
    tbl[0]  = '{1, 4'b0100, 1, 4'b1110, 1, 0, 0, 4'b0010,
                3'd0, 2'b11, 1, 1, 0, 0, 4'b0010};
    tbl[1]  = '{1, 4'b1010, 0, 4'b1110, 1, 0, 0, 4'b0100,
                3'd1, 2'b11, 1, 0, 0, 0, 4'b0100};
    tbl[2]  = '{1, 4'b0100, 0, 4'b0000, 1, 0, 0, 4'b1111,
                3'd0, 2'b00, 1, 1, 0, 0, 4'b0100};
    tbl[3]  = '{1, 4'b0010, 1, 4'b0001, 1, 0, 0, 4'b0000,
                3'd1, 2'b11, 0, 0, 0, 0, 4'b0100};
    tbl[4]  = '{1, 4'b0000, 1, 4'b1010, 1, 1, 1, 4'b1011,
                3'd2, 2'b10, 1, 1, 1, 1, 4'b1000};
    tbl[5]  = '{1, 4'b0001, 1, 4'b1011, 1, 0, 0, 4'b0001,
                3'd4, 2'b10, 1, 1, 0, 0, 4'b0000};
    tbl[6]  = '{1, 4'b1101, 0, 4'b1000, 1, 0, 0, 4'b1111,
                3'd5, 2'b00, 0, 0, 0, 0, 4'b0000};
    tbl[7]  = '{1, 4'b1011, 0, 4'b1110, 1, 0, 0, 4'b0011,
                3'd0, 2'b11, 1, 0, 0, 0, 4'b0011};
    tbl[8]  = '{0, 4'b0111, 1, 4'b0010, 0, 1, 0, 4'b1100,
                3'd0, 2'b00, 1, 0, 1, 0, 4'b0011};
    tbl[9]  = '{1, 4'b1100, 1, 4'b0110, 1, 0, 0, 4'b0100,
                3'd3, 2'b10, 1, 1, 0, 0, 4'b0111};
    tbl[10] = '{1, 4'b0010, 1, 4'b1111, 1, 1, 1, 4'b0000,
                3'd1, 2'b11, 0, 0, 0, 0, 4'b0111};
    tbl[11] = '{1, 4'b0100, 1, 4'b1101, 1, 0, 0, 4'b1000,
                3'd0, 2'b11, 1, 1, 0, 0, 4'b1000};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_flags = 4'b0000;
    drive(0, 4'b0000, 0, 4'b1110, 0, 0, 0);
    reset = 1'b1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 8'(out_valid), 8'h0);
    chk("rst_in_ready", 8'(in_ready), 8'h1);
    chk("rst_flags", 8'(flags), 8'h4);
    chk("rst_ctl", 8'(alu_control), 8'h0);
    chk("rst_flag_w", 8'(flag_w), 8'h0);
    chk("rst_cond_ex", 8'(cond_ex), 8'h0);
    chk("rst_reg_write", 8'(reg_write), 8'h0);
    chk("rst_mem_write", 8'(mem_write), 8'h0);
    chk("rst_pc_src", 8'(pc_src), 8'h0);
    chk("rst_illegal", 8'(illegal), 8'h0);

    // table: accept, inspect while stalled, then commit
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].cmd, tbl[i].s, tbl[i].cnd,
            tbl[i].rw, tbl[i].mw, tbl[i].ps);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 8'(out_valid), 8'h1);
      chk($sformatf("v%0d_in_ready", i), 8'(in_ready), 8'h0);
      chk($sformatf("v%0d_ctl", i), 8'(alu_control), 8'(tbl[i].e_ctl));
      chk($sformatf("v%0d_flag_w", i), 8'(flag_w), 8'(tbl[i].e_fw));
      chk($sformatf("v%0d_cond_ex", i), 8'(cond_ex), 8'(tbl[i].e_cx));
      chk($sformatf("v%0d_reg_write", i), 8'(reg_write), 8'(tbl[i].e_rw));
      chk($sformatf("v%0d_mem_write", i), 8'(mem_write), 8'(tbl[i].e_mw));
      chk($sformatf("v%0d_pc_src", i), 8'(pc_src), 8'(tbl[i].e_ps));
      out_ready = 1'b1;
      alu_flags = tbl[i].af;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_flags", i), 8'(flags), 8'(tbl[i].e_flags));
      chk($sformatf("v%0d_drained", i), 8'(out_valid), 8'h0);
    end

    // back-to-back CMP then ADD EQ sees the new Z immediately
    drive(1, 4'b1010, 0, 4'b1110, 1, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_cmp_rw", 8'(reg_write), 8'h0);
    chk("b2b_cmp_ctl", 8'(alu_control), 8'h1);
    chk("b2b_in_ready", 8'(in_ready), 8'h1);
    drive(1, 4'b0100, 1, 4'b0000, 1, 0, 0);
    alu_flags = 4'b0100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid", 8'(out_valid), 8'h1);
    chk("b2b_flags", 8'(flags), 8'h4);
    chk("b2b_add_cx", 8'(cond_ex), 8'h1);
    chk("b2b_add_rw", 8'(reg_write), 8'h1);
    alu_flags = 4'b0000;
    @(negedge clk);
    chk("b2b_add_flags", 8'(flags), 8'h0);
    chk("b2b_drained", 8'(out_valid), 8'h0);

    // stall ORR three cycles with a new request waiting
    drive(1, 4'b1100, 1, 4'b1110, 1, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1, 4'b0100, 0, 4'b1110, 1, 0, 0);
    alu_flags = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), 8'(out_valid), 8'h1);
      chk($sformatf("stall%0d_ctl", k), 8'(alu_control), 8'h3);
      chk($sformatf("stall%0d_fw", k), 8'(flag_w), 8'h2);
      chk($sformatf("stall%0d_in_ready", k), 8'(in_ready), 8'h0);
      chk($sformatf("stall%0d_flags", k), 8'(flags), 8'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rel_valid", 8'(out_valid), 8'h1);
    chk("rel_ctl", 8'(alu_control), 8'h0);
    chk("rel_fw", 8'(flag_w), 8'h0);
    chk("rel_flags", 8'(flags), 8'hc);
    @(negedge clk);
    chk("rel_drained", 8'(out_valid), 8'h0);
    chk("rel_flags2", 8'(flags), 8'hc);

    // illegal cmd
    drive(1, 4'b0111, 1, 4'b1110, 1, 1, 1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_ctl", 8'(alu_control), 8'h0);
    chk("ill_fw", 8'(flag_w), 8'h0);
    chk("ill_rw", 8'(reg_write), 8'h0);
    chk("ill_mw", 8'(mem_write), 8'h0);
    chk("ill_ps", 8'(pc_src), 8'h0);
    chk("ill_pre", 8'(illegal), 8'h0);
    out_ready = 1'b1;
    alu_flags = 4'b0011;
    @(negedge clk);
    chk("ill_flags", 8'(flags), 8'hc);
    chk("ill_post", 8'(illegal), 8'(TRAP));
    chk("ill_in_ready", 8'(in_ready), 8'(!TRAP));
    drive(1, 4'b0100, 0, 4'b1110, 1, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_next_valid", 8'(out_valid), 8'(!TRAP));
    chk("ill_sticky", 8'(illegal), 8'(TRAP));
    @(negedge clk);

    // reset clears trap; then reset with an instruction pending
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst2_illegal", 8'(illegal), 8'h0);
    chk("rst2_in_ready", 8'(in_ready), 8'h1);
    drive(1, 4'b0100, 1, 4'b1110, 1, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    alu_flags = 4'b1010;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst3_pre_flags", 8'(flags), 8'ha);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst3_pending", 8'(out_valid), 8'h1);
    reset     = 1'b1;
    out_ready = 1'b1;
    alu_flags = 4'b1111;
    @(negedge clk);
    chk("rst3_valid", 8'(out_valid), 8'h0);
    chk("rst3_flags", 8'(flags), 8'h4);
    reset = 1'b0;
    @(negedge clk);
    chk("rst3_in_ready", 8'(in_ready), 8'h1);
    chk("rst3_flags_hold", 8'(flags), 8'h4);
    chk("rst3_illegal", 8'(illegal), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decode_cond_unit.md
Name: alu_decode_cond_unit

Overview:
Next-generation ALU decoder for the single-issue ARM-subset core; also includes the conditional-execution logic.
- Decodes the data-processing cmd/S fields into a widened ALU control word and flag-write enables.
- Holds the NZCV flag register and evaluates the condition field against it.
- Gates register, memory and PC writes with the condition result.
- One registered decode stage with valid/ready handshakes on both sides; sits between the main decoder and the datapath.

Parameters:
ALUCTRL_W, 3, width of alu_control; legal range 3..8; upper bits beyond 3 are zero.
FLAG_RST, 4'b0000, NZCV value loaded on reset.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decode request valid
in_ready  out  1  stage can accept a request
alu_op  in  1  1 = data-processing, 0 = memory/branch (forces ADD)
funct_cmd  in  4  instr[24:21]
funct_s  in  1  instr[20]
cond  in  4  instr[31:28]
reg_w_in  in  1  unconditional register write from main decoder
mem_w_in  in  1  unconditional memory write
pc_s_in  in  1  unconditional PC source select
out_valid  out  1  decoded instruction valid
out_ready  in  1  datapath consumes and commits the instruction
alu_control  out  ALUCTRL_W  ALU operation code
flag_w  out  2  [1] = NZ write, [0] = CV write, before condition gating
cond_ex  out  1  condition passes
reg_write  out  1  reg_w_in & cond_ex & ~cmp-class
mem_write  out  1  mem_w_in & cond_ex
pc_src  out  1  pc_s_in & cond_ex
alu_flags  in  4  NZCV from the ALU; sampled on commit
flags  out  4  current NZCV register
illegal  out  1  illegal-opcode indication (see Optional Feature)

Behaviour:
- Reset (synchronous, highest priority):
  - out_valid=0, flags=FLAG_RST, illegal=0.
  - Stage registers cleared: alu_control=0, flag_w=0; cond_ex, reg_write, mem_write and pc_src all read 0.
  - An in-flight request is dropped. in_ready=1 the cycle after reset deasserts.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - Accept when in_valid & in_ready; the decode is presented on the next cycle (latency 1).
  - Commit when out_valid & out_ready.
  - If commit and a new accept occur in the same cycle, the stage reloads and out_valid stays 1 (full throughput).
  - Stage outputs hold stable while out_valid & ~out_ready.
- Decode, registered at accept:
  - alu_op=0: alu_control=ADD(0), flag_w=00.
  - alu_op=1, cmd → alu_control / flag_w when S=1:
    - 0100 ADD → 0 / 11
    - 0010 SUB → 1 / 11
    - 0000 AND → 2 / 10
    - 1100 ORR → 3 / 10
    - 0001 EOR → 4 / 10
    - 1101 MOV → 5 (pass B) / 10
    - 1010 CMP → 1 / 11, S forced to 1
    - 1011 CMN → 0 / 11, S forced to 1
  - S=0 → flag_w=00.
  - CMP/CMN are cmp-class: reg_write is forced to 0.
  - Any other cmd with alu_op=1 is illegal: alu_control=0, flag_w=00, reg_write=mem_write=pc_src=0. Every output is always driven; nothing holds a stale value.
- Condition (combinational from the stored cond and the current flags register):
  - 0000 EQ=Z; 0001 NE=~Z; 0010 CS=C; 0011 CC=~C; 0100 MI=N; 0101 PL=~N; 0110 VS=V; 0111 VC=~V
  - 1000 HI=C&~Z; 1001 LS=~C|Z; 1010 GE=N==V; 1011 LT=N!=V; 1100 GT=~Z&(N==V); 1101 LE=Z|(N!=V)
  - 1110 AL=1; 1111 = 0 (reserved, never executes).
- Flag update, on commit only:
  - NZ ← alu_flags[3:2] if flag_w[1] & cond_ex.
  - CV ← alu_flags[1:0] if flag_w[0] & cond_ex.
  - The following instruction's cond_ex sees the updated flags in the very next cycle; no bubble is required.
- Without a commit, flags never change, including while the stage is stalled.

Optional Feature:
ALU_DEC_ILLEGAL_TRAP_EN
- Defined:
  - illegal sets on commit of an illegal decode and is sticky until reset.
  - While illegal=1, in_ready=0 (pipe freezes).
- Undefined: illegal is tied 0; an illegal op silently commits as a NOP.

Decomposition:
- Package alu_dec_pkg: ALU op localparams (ADD..MOV), cmd encodings, cond-code encodings, NZCV bit indices.
- Sub-module cond_check: pure combinational cond[3:0] + NZCV → cond_ex; reusable in a later branch predictor.

Test Plan:
1. Reset with FLAG_RST=4'b0100, then drive in_valid=1, alu_op=1, cmd=0100, S=1, cond=1110 → next cycle alu_control=0, flag_w=11, cond_ex=1, reg_write=1; commit with alu_flags=4'b0010 → flags=0010.
2. CMP (cmd=1010, S=0, reg_w_in=1, cond=AL), commit alu_flags=0100, then back-to-back ADD with cond=EQ → CMP reg_write=0, flags=0100, ADD cond_ex=1 in the following cycle.
3. SUB S=1 with cond=NE while Z=1, alu_flags=0000 → cond_ex=0, reg_write=0, flags unchanged after commit.
4. Hold out_ready=0 for 3 cycles with a pending ORR → outputs stable, in_ready=0, flags unchanged; release → commit, next request accepted the same cycle.
5. cmd=0111 with alu_op=1 → alu_control=0, flag_w=00, all writes 0. With the macro defined: illegal=1 after commit, in_ready=0 until reset. Without it: illegal stays 0.
6. Assert reset while out_valid=1 → next cycle out_valid=0, flags=FLAG_RST, and the pending instruction never commits.
